bcd_digit_sequencer: RTL and testbench
======================================

# bcd_digit_sequencer

Upstream feeder for the nine-slot digit demultiplexer. Captures three 8-bit binary fields, converts each to three BCD digits with an iterative double-dabble, and presents the nine digits one at a time on a `sel`/`data` pair. Each digit is held long enough for the slower-clocked demultiplexer to sample it. Slot order is field 0 → slots 0–2, field 1 → slots 3–5, field 2 → slots 6–8; within a field the order is hundreds, tens, units.

## Interface
- `HOLD_CYCLES`, default 11111110: `clk_i` cycles each digit is held. Must be ≥ 2 consumer sample periods; the default is two periods of the 5555555-count divider.
- `clk_i`  in  1  system clock
- `rst_ni`  in  1  reset, asynchronous, active-low
- `start_i`  in  1  one-cycle request to capture the fields and run a sequence
- `field0_i`, `field1_i`, `field2_i`  in  8 each  binary values, 0–255
- `sel_o`  out  4  slot index 0–8; 15 = no slot
- `data_o`  out  4  BCD digit, or blank code 4'hF
- `wr_o`  out  1  high while `sel_o`/`data_o` carry a valid digit
- `busy_o`  out  1  high from the cycle after start is accepted until `done_o`
- `done_o`  out  1  one-cycle pulse when all nine digits have been emitted

## Operation
- States:
  - IDLE → CONV: `start_i`=1 in IDLE. Fields 0–2 are latched, field index f=0 is set, and the shift register is loaded with field f.
  - CONV: runs exactly 8 cycles. Each cycle, add 3 to every BCD nibble that is ≥ 5, then shift left by 1.
  - CONV → EMIT: after the 8th iteration, digit index d=0.
  - EMIT: holds digit d for HOLD_CYCLES cycles, then d increments.
  - After d=2: if f<2, set f=f+1, reload the shift register and return to CONV. Otherwise go to DONE.
  - DONE: lasts 1 cycle with `done_o`=1, then IDLE.
- EMIT outputs: `sel_o` = 3·f + d, `data_o` = the digit (d=0 hundreds, d=1 tens, d=2 units), `wr_o`=1.
- Outside EMIT: `sel_o`=15, `data_o`=0, `wr_o`=0. Slot 15 is not decoded by the consumer, so no write occurs.
- `start_i` outside IDLE is ignored; it is neither queued nor restarted.
- Field inputs are sampled only at start acceptance. Later changes do not affect the running sequence.
- Digit values are always 0–9 in BCD; the hundreds digit is ≤ 2. Conversion width is 20 bits (12 BCD + 8 binary).
- Hold counter width is `$clog2(HOLD_CYCLES)`. It counts 0..HOLD_CYCLES−1 and wraps to 0 on digit advance.

## Timing
- Reset values: `sel_o`=15, `data_o`=0, `wr_o`=0, `busy_o`=0, `done_o`=0. State = IDLE; counters and latched fields are 0.
- `rst_ni` low at any point, including mid-CONV or mid-EMIT, forces the reset values immediately. No partial sequence resumes.
- Edge k: start accepted. `busy_o`=1 from k+1.
- Digit (f,0) is valid from edge k+8+f·(8+3·HOLD_CYCLES). Each digit is valid for exactly HOLD_CYCLES cycles.
- Consecutive digits within a field are back-to-back with no gap in `wr_o`.
- Between fields there is an 8-cycle gap with `wr_o`=0 and `sel_o`=15.
- Total sequence: `done_o` is asserted 3·(8+3·HOLD_CYCLES) cycles after acceptance. `busy_o` drops in the same cycle as `done_o`.
- `start_i` in the DONE cycle is ignored. `start_i` in the first IDLE cycle after DONE is accepted.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `BCD_SEQ_LEADING_BLANK_EN`
  - Defined: a hundreds digit of 0 emits `data_o`=4'hF. Tens also emits 4'hF if both hundreds and tens are 0. Units is never blanked. `wr_o` and timing are unchanged.
  - Undefined: all digits emit their numeric value, including leading zeros.

## Structure
- Shared package `bcd_seq_pkg` holds:
  - the state enum (IDLE, CONV, EMIT, DONE)
  - `SEL_NONE`=4'd15
  - `BCD_BLANK`=4'hF
  - `N_FIELDS`=3, `DIGITS_PER_FIELD`=3, `CONV_ITER`=8
- Sub-module `bcd_dd_conv` holds the iterative 8-bit→3-digit double-dabble.
  - Ports: `load`, `bin[7:0]`, `step`, `bcd[11:0]`.
  - The top FSM drives `load`/`step` and owns all counters.

## Test plan
- Reset: assert `rst_ni`=0 mid-EMIT → all outputs return to reset values asynchronously. After release, `start_i` begins a fresh sequence from slot 0.
- HOLD_CYCLES=4, fields 123/45/7, start → slot/data sequence 0:1, 1:2, 2:3, 3:0, 4:4, 5:5, 6:0, 7:0, 8:7.
  - Each slot is held 4 cycles.
  - 8-cycle gaps between fields.
  - `done_o` at cycle 3·(8+12)=60 after acceptance.
- Same stimulus with `BCD_SEQ_LEADING_BLANK_EN` defined → slots 3, 6 and 7 emit 4'hF. All other slots and all timing are unchanged.
- Boundary values 255/0/200 → slots 0–8 = 2,5,5,0,0,0,2,0,0 without the macro. With the macro, slots 3,4 = F and slot 5 = 0.
- `start_i` pulsed during CONV and during EMIT, and field inputs changed mid-sequence → no restart, no output change, a single `done_o`.
- `start_i` held high continuously → back-to-back sequences. Each `done_o` is followed by acceptance one cycle later, and there are exactly 9 `wr_o` digit windows per sequence.

Source files
------------

// File: rtl/bcd_seq_pkg.sv
// Shared types, constants and the double-dabble step for the BCD digit sequencer.
package bcd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } seq_state_e;

    localparam logic [3:0] SEL_NONE  = 4'd15;
    localparam logic [3:0] BCD_BLANK = 4'hF;

    localparam int N_FIELDS         = 3;
    localparam int DIGITS_PER_FIELD = 3;
    localparam int CONV_ITER        = 8;

    // One double-dabble iteration on the BCD part: add 3 to nibbles >= 5, then
    // shift left taking the next binary bit in at the bottom.
    function automatic logic [11:0] dd_adjust_shift(input logic [11:0] bcd, input logic in_bit);
        logic [11:0] adj;
        for (int i = 0; i < 3; i++) begin
            adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
        end
        return {adj[10:0], in_bit};
    endfunction

endpackage

// File: rtl/bcd_dd_conv.sv
// Iterative 8-bit to 3-digit BCD converter: load once, then step CONV_ITER times.
module bcd_dd_conv
    import bcd_seq_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load,
    input  logic [7:0]  bin,
    input  logic        step,
    output logic [11:0] bcd
);

    // 12 BCD bits on top of the 8 binary bits still to be shifted in
    logic [19:0] sr_q;
    logic [19:0] sr_d;

    // Load a fresh value, or run one adjust-and-shift iteration
    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = {12'd0, bin};
        end else if (step) begin
            sr_d = {dd_adjust_shift(sr_q[19:8], sr_q[7]), sr_q[6:0], 1'b0};
        end
    end

    // Shift register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign bcd = sr_q[19:8];

endmodule

// File: rtl/bcd_digit_sequencer.sv
// Converts three captured 8-bit fields to BCD and emits the nine digits one at a
// time on sel_o/data_o, each held HOLD_CYCLES cycles for a slower consumer.
// Optional build macro: BCD_SEQ_LEADING_BLANK_EN (blank leading zero digits).
//
// state | meaning
// IDLE  | waiting for start_i
// CONV  | double-dabble of field f, CONV_ITER cycles
// EMIT  | presenting digit d of field f
// DONE  | one-cycle completion pulse
module bcd_digit_sequencer
    import bcd_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 11111110
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [7:0] field0_i,
    input  logic [7:0] field1_i,
    input  logic [7:0] field2_i,
    output logic [3:0] sel_o,
    output logic [3:0] data_o,
    output logic       wr_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int HW = $clog2(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [2:0]    CONV_LAST = 3'(CONV_ITER - 1);
    localparam logic [1:0]    DIG_LAST  = 2'(DIGITS_PER_FIELD - 1);
    localparam logic [1:0]    FLD_LAST  = 2'(N_FIELDS - 1);

    seq_state_e state_q, state_d;
    logic [1:0]    f_q, f_d;
    logic [1:0]    d_q, d_d;
    logic [2:0]    conv_cnt_q, conv_cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [7:0]    fld0_q, fld0_d, fld1_q, fld1_d, fld2_q, fld2_d;
    logic [3:0]    sel_q, sel_d, data_q, data_d;
    logic          wr_q, wr_d, busy_q, busy_d, done_q, done_d;

    logic          conv_load, conv_step;
    logic [7:0]    conv_bin;
    logic [11:0]   conv_bcd;
    logic [7:0]    cur_field, next_field;
    logic [11:0]   digit_src;

    bcd_dd_conv u_conv (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load   (conv_load),
        .bin    (conv_bin),
        .step   (conv_step),
        .bcd    (conv_bcd)
    );

    function automatic logic [3:0] pick_digit(input logic [11:0] bcd, input logic [1:0] d);
        logic [3:0] dig;
        case (d)
            2'd0:    dig = bcd[11:8];
            2'd1:    dig = bcd[7:4];
            default: dig = bcd[3:0];
        endcase
`ifdef BCD_SEQ_LEADING_BLANK_EN
        if (d == 2'd0 && bcd[11:8] == 4'd0) dig = BCD_BLANK;
        if (d == 2'd1 && bcd[11:4] == 8'd0) dig = BCD_BLANK;
`endif
        return dig;
    endfunction

    // Sequencing: next state, counters, converter control and registered outputs
    always_comb begin
        state_d    = state_q;
        f_d        = f_q;
        d_d        = d_q;
        conv_cnt_d = conv_cnt_q;
        hold_d     = hold_q;
        fld0_d     = fld0_q;
        fld1_d     = fld1_q;
        fld2_d     = fld2_q;
        conv_load  = 1'b0;
        conv_step  = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    fld0_d     = field0_i;
                    fld1_d     = field1_i;
                    fld2_d     = field2_i;
                    f_d        = 2'd0;
                    conv_cnt_d = '0;
                    conv_load  = 1'b1;
                    state_d    = CONV;
                end
            end
            CONV: begin
                busy_d    = 1'b1;
                conv_step = 1'b1;
                if (conv_cnt_q == CONV_LAST) begin
                    conv_cnt_d = '0;
                    d_d        = 2'd0;
                    hold_d     = '0;
                    state_d    = EMIT;
                end else begin
                    conv_cnt_d = conv_cnt_q + 3'd1;
                end
            end
            EMIT: begin
                busy_d = 1'b1;
                if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    if (d_q == DIG_LAST) begin
                        d_d = 2'd0;
                        if (f_q < FLD_LAST) begin
                            f_d        = f_q + 2'd1;
                            conv_cnt_d = '0;
                            conv_load  = 1'b1;
                            state_d    = CONV;
                        end else begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = DONE;
                        end
                    end else begin
                        d_d = d_q + 2'd1;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (f_q)
            2'd0:    cur_field = fld0_q;
            2'd1:    cur_field = fld1_q;
            default: cur_field = fld2_q;
        endcase
        case (f_d)
            2'd0:    next_field = fld0_q;
            2'd1:    next_field = fld1_q;
            default: next_field = fld2_q;
        endcase
        conv_bin = (state_q == IDLE) ? field0_i : next_field;

        // On entry to EMIT the final iteration is still in flight, so apply it here
        digit_src = (state_q == CONV) ? dd_adjust_shift(conv_bcd, cur_field[0]) : conv_bcd;

        wr_d   = (state_d == EMIT);
        sel_d  = wr_d ? ({2'b00, f_d} * 4'd3 + {2'b00, d_d}) : SEL_NONE;
        data_d = wr_d ? pick_digit(digit_src, d_d) : 4'd0;
    end

    // State, counters, latched fields and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            f_q        <= '0;
            d_q        <= '0;
            conv_cnt_q <= '0;
            hold_q     <= '0;
            fld0_q     <= '0;
            fld1_q     <= '0;
            fld2_q     <= '0;
            sel_q      <= SEL_NONE;
            data_q     <= '0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            f_q        <= f_d;
            d_q        <= d_d;
            conv_cnt_q <= conv_cnt_d;
            hold_q     <= hold_d;
            fld0_q     <= fld0_d;
            fld1_q     <= fld1_d;
            fld2_q     <= fld2_d;
            sel_q      <= sel_d;
            data_q     <= data_d;
            wr_q       <= wr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign sel_o  = sel_q;
    assign data_o = data_q;
    assign wr_o   = wr_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_bcd_digit_sequencer.sv
// Scoreboard bench for bcd_digit_sequencer with HOLD_CYCLES=4. Expected digit
// windows and done pulses are queued by the stimulus; a negedge monitor checks them.
module tb_bcd_digit_sequencer;

    localparam int H      = 4;
    localparam int STRIDE = 8 + 3 * H;

    typedef logic [3:0] dig9_t [9];
    typedef struct {
        logic [3:0] sel;
        logic [3:0] data;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] f0 = '0, f1 = '0, f2 = '0;
    logic [3:0] sel_o, data_o;
    logic       wr_o, busy_o, done_o;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    int   done_q[$];

    dig9_t t_a, t_b;

    bcd_digit_sequencer #(.HOLD_CYCLES(H)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (start),
        .field0_i (f0),
        .field1_i (f1),
        .field2_i (f2),
        .sel_o    (sel_o),
        .data_o   (data_o),
        .wr_o     (wr_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_seq(input dig9_t dg, input int k);
        exp_t e;
        for (int f = 0; f < 3; f++) begin
            for (int d = 0; d < 3; d++) begin
                e.sel  = 4'(3 * f + d);
                e.data = dg[3 * f + d];
                e.cyc  = k + 8 + f * STRIDE + d * H;
                exp_q.push_back(e);
            end
        end
        done_q.push_back(k + 3 * STRIDE);
    endfunction

    // Monitor: digit windows, idle-bus values and done pulses
    initial begin
        bit         win_open = 0;
        logic [3:0] win_sel = '0, win_data = '0;
        int         win_len = 0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                win_open = 0;
            end else begin
                if (wr_o) begin
                    if (!win_open || sel_o != win_sel) begin
                        if (win_open) chk("hold_len", win_len, H);
                        win_open = 1;
                        win_sel  = sel_o;
                        win_data = data_o;
                        win_len  = 1;
                        if (exp_q.size() == 0) begin
                            chk("unexpected_digit_sel", int'(sel_o), 15);
                        end else begin
                            e = exp_q.pop_front();
                            chk("digit_sel", int'(sel_o), int'(e.sel));
                            chk("digit_data", int'(data_o), int'(e.data));
                            chk("digit_cycle", cyc, e.cyc);
                        end
                    end else begin
                        win_len++;
                        chk("data_stable", int'(data_o), int'(win_data));
                    end
                end else begin
                    if (win_open) chk("hold_len", win_len, H);
                    win_open = 0;
                    chk("idle_sel", int'(sel_o), 15);
                    chk("idle_data", int'(data_o), 0);
                end
                if (done_o) begin
                    chk("busy_at_done", int'(busy_o), 0);
                    if (done_q.size() == 0) chk("unexpected_done", 1, 0);
                    else chk("done_cycle", cyc, done_q.pop_front());
                end
            end
        end
    end

    // Issue a one-cycle start from a negedge; returns the accepting edge number
    task automatic start_seq(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input dig9_t dg, output int k);
        f0 = a; f1 = b; f2 = c;
        start = 1'b1;
        k = cyc + 1;
        push_seq(dg, k);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("busy_at_k", int'(busy_o), 0);
        @(negedge clk);
        chk("busy_at_k1", int'(busy_o), 1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0) && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) chk("timeout_pending", exp_q.size() + done_q.size(), 0);
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        int k, k1;
`ifdef BCD_SEQ_LEADING_BLANK_EN
        t_a = '{4'd1, 4'd2, 4'd3, 4'hF, 4'd4, 4'd5, 4'hF, 4'hF, 4'd7};
        t_b = '{4'd2, 4'd5, 4'd5, 4'hF, 4'hF, 4'd0, 4'd2, 4'd0, 4'd0};
`else
        t_a = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd4, 4'd5, 4'd0, 4'd0, 4'd7};
        t_b = '{4'd2, 4'd5, 4'd5, 4'd0, 4'd0, 4'd0, 4'd2, 4'd0, 4'd0};
`endif
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_sel", int'(sel_o), 15);
        chk("rst_data", int'(data_o), 0);
        chk("rst_wr", int'(wr_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 123 / 45 / 7
        start_seq(8'd123, 8'd45, 8'd7, t_a, k);
        wait_idle();

        // Boundary values 255 / 0 / 200
        start_seq(8'd255, 8'd0, 8'd200, t_b, k);
        wait_idle();

        // Start pulses during CONV and EMIT with field changes: ignored
        start_seq(8'd123, 8'd45, 8'd7, t_a, k);
        f0 = 8'd99; f1 = 8'd98; f2 = 8'd97;
        wait_until(k + 3);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_until(k + 15);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle();
        repeat (20) @(negedge clk);

        // Asynchronous reset mid-EMIT, then a fresh sequence
        start_seq(8'd123, 8'd45, 8'd7, t_a, k);
        wait_until(k + 10);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_sel", int'(sel_o), 15);
        chk("midrst_data", int'(data_o), 0);
        chk("midrst_wr", int'(wr_o), 0);
        chk("midrst_busy", int'(busy_o), 0);
        chk("midrst_done", int'(done_o), 0);
        exp_q.delete();
        done_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        start_seq(8'd255, 8'd0, 8'd200, t_b, k);
        wait_idle();

        // start held high: back-to-back sequences, next acceptance one idle cycle after done
        f0 = 8'd123; f1 = 8'd45; f2 = 8'd7;
        start = 1'b1;
        k1 = cyc + 1;
        push_seq(t_a, k1);
        push_seq(t_a, k1 + 3 * STRIDE + 2);
        wait_until(k1 + 3 * STRIDE + 2);
        start = 1'b0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
